// File: rtl/plotter_step_axil_slave.sv
// AXI-Lite slave driving a single stepper axis: CTRL/STEPS/PERIOD/STATUS registers
// and a step engine that emits STEPS pulses of P clocks high / P clocks low.
module plotter_step_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            STEP_OUT,
   output logic                            DIR_OUT,
   output logic                            EN_OUT
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STEPS  = 2'd1;
   localparam logic [1:0] A_PERIOD = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   state_t      state, state_nx;
   logic        aw_rdy, ar_rdy, b_vld, r_vld;
   logic [31:0] r_data, rd_mux;
   logic        ctrl_dir, ctrl_en, done, dir_out;
   logic [15:0] steps, period, remaining, p_lat, cnt;
   logic        wr_hs, rd_hs, ctrl_wr, start_req, stop_req, phase_end, busy;
   logic        unused_bits;

   assign unused_bits = ^{S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2],
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_hs     = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_hs     = ar_rdy & S_AXI_ARVALID;
   assign ctrl_wr   = wr_hs & (S_AXI_AWADDR[3:2] == A_CTRL) & S_AXI_WSTRB[0];
   assign start_req = ctrl_wr & S_AXI_WDATA[0] & S_AXI_WDATA[2];
   assign stop_req  = ctrl_wr & (S_AXI_WDATA[3] | ~S_AXI_WDATA[2]);
   assign busy      = (state != S_IDLE);
   assign phase_end = (cnt == p_lat - 16'd1);

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_BVALID  = b_vld;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = r_vld;
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RRESP   = 2'b00;
   assign DIR_OUT       = dir_out;
   assign EN_OUT        = ctrl_en;

   always_comb begin
      rd_mux = '0;
      unique case (S_AXI_ARADDR[3:2])
         A_CTRL:   rd_mux = {28'd0, 1'b0, ctrl_en, ctrl_dir, 1'b0};
         A_STEPS:  rd_mux = {16'd0, steps};
         A_PERIOD: rd_mux = {16'd0, period};
         default:  rd_mux = {remaining, 14'd0, done, busy};
      endcase
   end

   // Ready strobes are registered one-cycle pulses; a pending response blocks acceptance.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_rdy <= 1'b0;
         ar_rdy <= 1'b0;
         b_vld  <= 1'b0;
         r_vld  <= 1'b0;
         r_data <= '0;
      end else begin
         aw_rdy <= ~aw_rdy & ~b_vld & S_AXI_AWVALID & S_AXI_WVALID;
         ar_rdy <= ~ar_rdy & ~r_vld & S_AXI_ARVALID;
         if (wr_hs)             b_vld <= 1'b1;
         else if (S_AXI_BREADY) b_vld <= 1'b0;
         if (rd_hs) begin
            r_vld  <= 1'b1;
            r_data <= rd_mux;
         end else if (S_AXI_RREADY) begin
            r_vld  <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ctrl_dir <= 1'b0;
         ctrl_en  <= 1'b0;
         steps    <= '0;
         period   <= '0;
      end else if (wr_hs) begin
         unique case (S_AXI_AWADDR[3:2])
            A_CTRL: if (S_AXI_WSTRB[0]) {ctrl_en, ctrl_dir} <= S_AXI_WDATA[2:1];
            A_STEPS: begin
               if (S_AXI_WSTRB[0]) steps[7:0]  <= S_AXI_WDATA[7:0];
               if (S_AXI_WSTRB[1]) steps[15:8] <= S_AXI_WDATA[15:8];
            end
            A_PERIOD: begin
               if (S_AXI_WSTRB[0]) period[7:0]  <= S_AXI_WDATA[7:0];
               if (S_AXI_WSTRB[1]) period[15:8] <= S_AXI_WDATA[15:8];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (start_req && steps != '0) state_nx = S_HIGH;
         S_HIGH: begin
            if (stop_req)       state_nx = S_IDLE;
            else if (phase_end) state_nx = S_LOW;
         end
         S_LOW: begin
            if (stop_req)       state_nx = S_IDLE;
            else if (phase_end) state_nx = (remaining == 16'd1) ? S_IDLE : S_HIGH;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      STEP_OUT = (state == S_HIGH);
   end

   // Abort keeps remaining and DONE untouched so software can see how far the move got.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         remaining <= '0;
         p_lat     <= '0;
         cnt       <= '0;
         done      <= 1'b0;
         dir_out   <= 1'b0;
      end else if (state == S_IDLE) begin
         if (start_req) begin
            if (steps != '0) begin
               remaining <= steps;
               p_lat     <= (period < 16'd2) ? 16'd2 : period;
               cnt       <= '0;
               dir_out   <= S_AXI_WDATA[1];
               done      <= 1'b0;
            end else begin
               done      <= 1'b1;
            end
         end
      end else if (!stop_req) begin
         if (phase_end) begin
            cnt <= '0;
            if (state == S_LOW) begin
               remaining <= remaining - 16'd1;
               if (remaining == 16'd1) done <= 1'b1;
            end
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_plotter_step_axil_slave.sv
// Randomized bench for plotter_step_axil_slave: a queue-based waveform model predicts
// STEP_OUT and register contents; a negedge compare process checks every cycle.
module tb_plotter_step_axil_slave;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;
   logic        STEP_OUT, DIR_OUT, EN_OUT;

   plotter_step_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
      .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
      .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
      .STEP_OUT(STEP_OUT), .DIR_OUT(DIR_OUT), .EN_OUT(EN_OUT)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_en = 0, m_dir = 0, m_dirout = 0, m_done = 0;
   logic        m_bvalid = 0, m_rvalid = 0;
   logic [15:0] m_steps = 0, m_period = 0, m_rem = 0;
   logic [31:0] m_rdata = 0;
   bit          wave[$];   // expected STEP_OUT for this and future cycles
   logic        m_wr, m_rd, m_ctrl, m_stop, m_busy_pre, m_v;
   int          m_p;

   function automatic logic [31:0] m_read(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return {29'd0, m_en, m_dir, 1'b0};
         2'd1:    return {16'd0, m_steps};
         2'd2:    return {16'd0, m_period};
         default: return {m_rem, 14'd0, m_done, wave.size() != 0};
      endcase
   endfunction

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         m_en = 0; m_dir = 0; m_dirout = 0; m_done = 0;
         m_bvalid = 0; m_rvalid = 0; m_rdata = 0;
         m_steps = 0; m_period = 0; m_rem = 0;
         wave.delete();
      end else begin
         m_wr = AWVALID & AWREADY & WVALID;
         m_rd = ARVALID & ARREADY;
         if (m_bvalid && BREADY) m_bvalid = 0;
         if (m_wr) m_bvalid = 1;
         if (m_rvalid && RREADY) m_rvalid = 0;
         if (m_rd) begin
            m_rvalid = 1;
            m_rdata  = m_read(ARADDR);
         end
         m_busy_pre = (wave.size() != 0);
         m_ctrl = m_wr && AWADDR[3:2] == 2'd0 && WSTRB[0];
         m_stop = m_ctrl && (WDATA[3] || !WDATA[2]);
         if (m_busy_pre) begin
            if (m_stop) wave.delete();
            else begin
               m_v = wave.pop_front();
               // a pulse is complete when its low phase ends
               if (!m_v && (wave.size() == 0 || wave[0])) begin
                  m_rem = m_rem - 16'd1;
                  if (wave.size() == 0) m_done = 1;
               end
            end
         end else if (m_ctrl && WDATA[0] && WDATA[2]) begin
            if (m_steps != 0) begin
               m_p = (m_period < 2) ? 2 : int'(m_period);
               for (int i = 0; i < int'(m_steps); i++) begin
                  for (int j = 0; j < m_p; j++) wave.push_back(1'b1);
                  for (int j = 0; j < m_p; j++) wave.push_back(1'b0);
               end
               m_rem = m_steps; m_done = 0; m_dirout = WDATA[1];
            end else m_done = 1;
         end
         if (m_wr) begin
            case (AWADDR[3:2])
               2'd0: if (WSTRB[0]) begin m_en = WDATA[2]; m_dir = WDATA[1]; end
               2'd1: begin
                  if (WSTRB[0]) m_steps[7:0]  = WDATA[7:0];
                  if (WSTRB[1]) m_steps[15:8] = WDATA[15:8];
               end
               2'd2: begin
                  if (WSTRB[0]) m_period[7:0]  = WDATA[7:0];
                  if (WSTRB[1]) m_period[15:8] = WDATA[15:8];
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- compare process ----------------
   int  rises = 0, high_cycles = 0;
   logic prev_step = 0;

   always @(negedge ACLK) begin
      if (ARESET) begin
         chk("rst_step", {31'd0, STEP_OUT}, 0);
         chk("rst_dir", {31'd0, DIR_OUT}, 0);
         chk("rst_en", {31'd0, EN_OUT}, 0);
         chk("rst_rdy", {29'd0, AWREADY, WREADY, ARREADY}, 0);
         chk("rst_valid", {30'd0, BVALID, RVALID}, 0);
         chk("rst_rdata", RDATA, 0);
      end else begin
         chk("step_out", {31'd0, STEP_OUT}, {31'd0, (wave.size() != 0) ? wave[0] : 1'b0});
         chk("dir_out", {31'd0, DIR_OUT}, {31'd0, m_dirout});
         chk("en_out", {31'd0, EN_OUT}, {31'd0, m_en});
         chk("bvalid", {31'd0, BVALID}, {31'd0, m_bvalid});
         chk("rvalid", {31'd0, RVALID}, {31'd0, m_rvalid});
         if (m_rvalid) chk("rdata", RDATA, m_rdata);
         chk("resp", {28'd0, BRESP, RRESP}, 0);
         chk("aw_w_ready_pair", {31'd0, AWREADY}, {31'd0, WREADY});
         chk("awready_while_b", {31'd0, AWREADY & m_bvalid}, 0);
         chk("arready_while_r", {31'd0, ARREADY & m_rvalid}, 0);
      end
      if (STEP_OUT === 1'b1) high_cycles++;
      if (STEP_OUT === 1'b1 && !prev_step) rises++;
      prev_step = (STEP_OUT === 1'b1);
   end

   // ---------------- bus drivers ----------------
   task automatic wr_addr_data(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(negedge ACLK);
      AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
      while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
      if (!AWREADY) chk("aw_timeout", {31'd0, AWREADY}, 1);
      @(posedge ACLK); #1;
      AWVALID = 0; WVALID = 0;
   endtask

   task automatic wr_resp(input int bdelay);
      int n = 0;
      repeat (bdelay) @(negedge ACLK);
      BREADY = 1;
      while (!BVALID && n < 100) begin @(negedge ACLK); n++; end
      if (!BVALID) chk("b_timeout", {31'd0, BVALID}, 1);
      @(posedge ACLK); #1;
      BREADY = 0;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bdelay);
      wr_addr_data(a, d, s);
      wr_resp(bdelay);
   endtask

   task automatic axi_read(input logic [3:0] a, input int rdelay, output logic [31:0] d);
      int n = 0;
      @(negedge ACLK);
      ARADDR = a; ARVALID = 1;
      while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
      if (!ARREADY) chk("ar_timeout", {31'd0, ARREADY}, 1);
      @(posedge ACLK); #1;
      ARVALID = 0;
      repeat (rdelay) @(negedge ACLK);
      RREADY = 1;
      n = 0;
      while (!RVALID && n < 100) begin @(negedge ACLK); n++; end
      if (!RVALID) chk("r_timeout", {31'd0, RVALID}, 1);
      d = RDATA;
      @(posedge ACLK); #1;
      RREADY = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [31:0] d, d2;
   int r0, h0, n;

   initial begin
      ARESET = 1; AWADDR = 0; ARADDR = 0; AWVALID = 0; WVALID = 0; WDATA = 0; WSTRB = 0;
      BREADY = 0; ARVALID = 0; RREADY = 0;
      repeat (3) @(negedge ACLK);
      ARESET = 0;

      axi_read(4'hC, 0, d);                  chk("status_after_reset", d, 32'h0);

      axi_write(4'h4, 32'h1234, 4'hF, 0);
      axi_write(4'h8, 32'h0010, 4'hF, 0);
      axi_read(4'h4, 0, d);                  chk("steps_rb", d, 32'h0000_1234);
      axi_read(4'h8, 0, d);                  chk("period_rb", d, 32'h0000_0010);
      axi_write(4'h4, 32'hFFFF_5678, 4'b0010, 1);
      axi_read(4'h4, 0, d);                  chk("steps_strb_byte1", d, 32'h0000_5634);

      // three pulses, P=4
      axi_write(4'h4, 3, 4'hF, 0);
      axi_write(4'h8, 4, 4'hF, 0);
      r0 = rises; h0 = high_cycles;
      axi_write(4'h0, 32'h7, 4'hF, 0);
      repeat (40) @(negedge ACLK);
      chk("move3_pulses", rises - r0, 3);
      chk("move3_high", high_cycles - h0, 12);
      chk("move3_dir", {31'd0, DIR_OUT}, 1);
      axi_read(4'hC, 0, d);                  chk("move3_status", d, 32'h0000_0002);

      // PERIOD=0 clamps to 2
      axi_write(4'h8, 0, 4'hF, 0);
      axi_write(4'h4, 1, 4'hF, 0);
      r0 = rises; h0 = high_cycles;
      axi_write(4'h0, 32'h7, 4'hF, 0);
      repeat (12) @(negedge ACLK);
      chk("min_period_pulses", rises - r0, 1);
      chk("min_period_high", high_cycles - h0, 2);
      axi_read(4'h0, 0, d);                  chk("ctrl_rb", d, 32'h0000_0006);

      // abort after two pulses
      axi_write(4'h4, 10, 4'hF, 0);
      axi_write(4'h8, 4, 4'hF, 0);
      r0 = rises;
      axi_write(4'h0, 32'h7, 4'hF, 0);
      n = 0;
      while (rises - r0 < 3 && n < 300) begin @(negedge ACLK); n++; end
      chk("abort_wait", rises - r0, 3);
      axi_write(4'h0, 32'hC, 4'hF, 0);
      chk("abort_step_low", {31'd0, STEP_OUT}, 0);
      axi_read(4'hC, 0, d);                  chk("abort_status", d, 32'h0008_0000);

      // STEPS=0 start sets DONE only
      axi_write(4'h4, 0, 4'hF, 0);
      axi_write(4'h0, 32'h5, 4'hF, 0);
      axi_read(4'hC, 0, d);                  chk("zero_steps_status", d, 32'h0008_0002);

      // simultaneous read and write to the same register
      fork
         axi_write(4'h4, 32'h77, 4'hF, 0);
         axi_read(4'h4, 0, d2);
      join
      chk("rw_same_cycle_old", d2, 32'h0);
      axi_read(4'h4, 0, d);                  chk("rw_same_cycle_new", d, 32'h77);

      // held B response blocks the next write
      wr_addr_data(4'h8, 32'h6, 4'hF);
      @(negedge ACLK);
      AWADDR = 4'h4; WDATA = 32'h2; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
      repeat (5) begin
         @(negedge ACLK);
         chk("aw_blocked", {31'd0, AWREADY}, 0);
      end
      fork
         wr_resp(0);
         wr_addr_data(4'h4, 32'h2, 4'hF);
      join
      wr_resp(0);
      axi_read(4'h8, 5, d);                  chk("held_read_period", d, 32'h6);
      axi_read(4'h4, 0, d);                  chk("second_write_steps", d, 32'h2);

      // randomized traffic
      for (int k = 0; k < 250; k++) begin
         int op;
         logic [3:0] a;
         logic [31:0] wd;
         op = $urandom_range(0, 9);
         a  = 4'($urandom_range(0, 3) * 4);
         wd = $urandom;
         if (a == 4'h0) begin
            wd[2] = ($urandom_range(0, 7) != 0);
            wd[3] = ($urandom_range(0, 9) == 0);
         end else if (a == 4'h4) wd[15:0] = 16'($urandom_range(0, 4));
         else if (a == 4'h8)     wd[15:0] = 16'($urandom_range(0, 5));
         if (op < 4)
            axi_write(a, wd, (a == 4'h0) ? 4'hF : 4'($urandom), $urandom_range(0, 3));
         else if (op < 7)
            axi_read(4'($urandom_range(0, 3) * 4), $urandom_range(0, 3), d);
         else if (op == 7) begin
            fork
               axi_write(a, wd, (a == 4'h0) ? 4'hF : 4'($urandom), 0);
               axi_read(4'($urandom_range(0, 3) * 4), 0, d2);
            join
         end else
            repeat ($urandom_range(1, 20)) @(negedge ACLK);
      end

      // pending write response dropped by reset
      axi_write(4'h0, 32'h4, 4'hF, 0);
      repeat (30) @(negedge ACLK);
      wr_addr_data(4'h8, 32'h3, 4'hF);
      repeat (2) @(negedge ACLK);
      #2 ARESET = 1;
      #1 chk("pending_b_reset", {31'd0, BVALID}, 0);
      @(negedge ACLK);
      ARESET = 0;
      repeat (4) @(negedge ACLK);
      axi_read(4'h8, 0, d);                  chk("period_after_reset", d, 32'h0);

      // asynchronous reset during the HIGH phase
      axi_write(4'h4, 5, 4'hF, 0);
      axi_write(4'h8, 3, 4'hF, 0);
      axi_write(4'h0, 32'h7, 4'hF, 0);
      n = 0;
      while (STEP_OUT !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
      chk("high_before_reset", {31'd0, STEP_OUT}, 1);
      #2 ARESET = 1;
      #1;
      chk("async_rst_outs", {29'd0, STEP_OUT, DIR_OUT, EN_OUT}, 0);
      chk("async_rst_bus", {27'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID}, 0);
      repeat (2) @(negedge ACLK);
      ARESET = 0;
      axi_read(4'hC, 0, d);                  chk("status_after_async_rst", d, 32'h0);
      repeat (5) @(negedge ACLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
